mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter on the core's data-memory valid/ready bus, alongside the dual-port RAM. An upstream address decoder gates valid_i to this block for its window. The block buffers written bytes in a small FIFO and serialises them 8N1, LSB first, on tx_o. It also provides status and baud-divisor registers, and an idle-level interrupt.

---
 rtl/mmio_uart_tx.sv | 142 ++++++++++++++
 tb/tb_mmio_uart_tx.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO, status/divisor registers and idle irq
module mmio_uart_tx #(
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 434,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  input  logic [3:0]            we_i,
  output logic [31:0]           rdata_o,
  output logic                  tx_o,
  output logic                  irq_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [15:0]   div_q;
  logic [1:0]    state;
  logic [15:0]   bit_cnt, bit_len;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  logic [1:0]  sel;
  logic        full, empty, busy, req, push_req, accept, push, pop, bit_done;
  logic [15:0] eff_div_m1;
  logic [31:0] rd_val;
  logic        unused_bits;

  assign unused_bits = ^{addr_i[ADDR_WIDTH-1:4], addr_i[1:0], wdata_i[31:16], we_i[3:2]};

  assign sel      = addr_i[3:2];
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign busy     = (state != S_IDLE);
  assign req      = valid_i && !ready_o;
  assign push_req = req && (sel == 2'd0) && we_i[0];
  // A TXDATA write into a full FIFO is not acknowledged until a slot has freed.
  assign accept   = req && !(push_req && full);
  assign push     = push_req && !full;
  assign bit_done = (bit_cnt == 16'd0);
  assign pop      = !empty && ((state == S_IDLE) || ((state == S_STOP) && bit_done));
  assign eff_div_m1 = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;

  always_comb begin
    rd_val = 32'd0;
    case (sel)
      2'd1:    rd_val = {16'd0, 8'(count), 5'd0, busy, empty, full};
      2'd2:    rd_val = {16'd0, div_q};
      default: rd_val = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata_i[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_o <= 1'b0;
      rdata_o <= 32'd0;
      div_q   <= 16'(DEFAULT_DIV);
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      ready_o <= accept;
      if (accept) rdata_o <= (we_i == 4'd0) ? rd_val : 32'd0;
      if (accept && (sel == 2'd2)) begin
        if (we_i[0]) div_q[7:0]  <= wdata_i[7:0];
        if (we_i[1]) div_q[15:8] <= wdata_i[15:8];
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // bit_cnt counts down the current bit period; the divisor is frozen per frame in bit_len.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      tx_o    <= 1'b1;
      irq_o   <= 1'b1;
      bit_cnt <= 16'd0;
      bit_len <= 16'd0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
    end else begin
      irq_o <= empty && (state == S_IDLE);
      if (pop) begin
        state   <= S_START;
        tx_o    <= 1'b0;
        shreg   <= mem[rd_ptr];
        bit_len <= eff_div_m1;
        bit_cnt <= eff_div_m1;
        bit_idx <= 3'd0;
      end else if (state != S_IDLE) begin
        if (!bit_done) begin
          bit_cnt <= bit_cnt - 16'd1;
        end else begin
          bit_cnt <= bit_len;
          case (state)
            S_START: begin
              state <= S_DATA;
              tx_o  <= shreg[0];
              shreg <= shreg >> 1;
            end
            S_DATA: begin
              if (bit_idx == 3'd7) begin
                state <= S_STOP;
                tx_o  <= 1'b1;
              end else begin
                bit_idx <= bit_idx + 3'd1;
                tx_o    <= shreg[0];
                shreg   <= shreg >> 1;
              end
            end
            default: begin
              state <= S_IDLE;
              tx_o  <= 1'b1;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - self-checking bench for mmio_uart_tx
module tb_mmio_uart_tx;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] wdata_i = 32'd0;
  logic [3:0]  we_i = 4'd0;
  logic [31:0] rdata_o;
  logic        tx_o, irq_o;

  mmio_uart_tx #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(434), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .addr_i(addr_i),
    .wdata_i(wdata_i), .we_i(we_i), .rdata_o(rdata_o), .tx_o(tx_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct { logic [7:0] data; int div; } frame_t;
  frame_t exp_q[$];

  // Line monitor: every frame must be start, 8 data bits LSB first, stop, each div cycles long.
  bit     mon_in_frame = 0;
  bit     mon_skip = 0;
  int     mon_k = 0, mon_errs = 0, mon_gap = 0, last_gap = 0, frames_seen = 0;
  frame_t cur;

  function automatic logic exp_level(frame_t f, int k);
    int b = k / f.div;
    if (b == 0) return 1'b0;
    if (b >= 9) return 1'b1;
    return f.data[b-1];
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      mon_in_frame = 0;
      mon_gap = 0;
    end else begin
      if (!mon_in_frame && tx_o === 1'b0) begin
        frames_seen++;
        last_gap = mon_gap;
        mon_gap = 0;
        mon_in_frame = 1;
        mon_k = 0;
        mon_errs = 0;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_frame: start bit seen, expected idle line");
          mon_skip = 1;
          cur.data = 8'd0;
          cur.div = 1;
        end else begin
          mon_skip = 0;
          cur = exp_q.pop_front();
        end
      end
      if (mon_in_frame) begin
        if (!mon_skip && tx_o !== exp_level(cur, mon_k)) mon_errs++;
        mon_k++;
        if (mon_k == 10 * cur.div) begin
          mon_in_frame = 0;
          if (!mon_skip)
            check($sformatf("frame_%02h_div%0d_bad_samples", cur.data, cur.div), 32'(mon_errs), 32'd0);
        end
      end else if (tx_o === 1'b1) begin
        mon_gap++;
      end
    end
  end

  task automatic bus(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                     output logic [31:0] rd, output int lat);
    if (ready_o === 1'b1) begin @(posedge clk); #1; end
    valid_i = 1'b1; addr_i = a; we_i = we; wdata_i = wd; lat = 0;
    do begin @(posedge clk); #1; lat++; end while (ready_o !== 1'b1 && lat < 500);
    rd = rdata_o;
    valid_i = 1'b0; we_i = 4'd0; addr_i = 32'd0; wdata_i = 32'd0;
    if (ready_o !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL bus_timeout: no ready_o after %0d cycles, expected an acknowledge", lat);
    end
  endtask

  task automatic set_div(input logic [15:0] d);
    logic [31:0] rd; int lat;
    bus(32'h8, 4'b0011, {16'hFFFF, d}, rd, lat);
  endtask

  task automatic push(input logic [7:0] b, input int d, output int lat);
    logic [31:0] rd; logic [3:0] we;
    we = {3'($urandom), 1'b1};
    exp_q.push_back('{data: b, div: d});
    bus(32'h0, we, {24'($urandom), b}, rd, lat);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (!(exp_q.size() == 0 && !mon_in_frame && irq_o === 1'b1) && k < budget) begin
      @(posedge clk); #1; k++;
    end
    if (k >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle_timeout: %0d frames still pending after %0d cycles, expected 0", exp_q.size(), k);
    end
  endtask

  typedef struct { logic [31:0] addr; logic [3:0] we; logic [31:0] wdata; logic [31:0] exp; } vec_t;
  vec_t tbl[14];

  initial begin
    logic [31:0] rd;
    int lat, k, fsn, d, n;

    tbl[0]  = '{32'h0000_0004, 4'b0000, 32'h0,          32'h0000_0002};
    tbl[1]  = '{32'h4000_0008, 4'b0000, 32'h0,          32'd434};
    tbl[2]  = '{32'h0000_000C, 4'b0000, 32'h0,          32'h0};
    tbl[3]  = '{32'h0000_0000, 4'b0000, 32'h0,          32'h0};
    tbl[4]  = '{32'h0000_0008, 4'b0011, 32'hFFFF_1234,  32'h0};
    tbl[5]  = '{32'h0000_0008, 4'b0000, 32'h0,          32'h0000_1234};
    tbl[6]  = '{32'h0000_0008, 4'b0010, 32'h0000_AB00,  32'h0};
    tbl[7]  = '{32'h8000_0008, 4'b0000, 32'h0,          32'h0000_AB34};
    tbl[8]  = '{32'h0000_0004, 4'b1111, 32'hFFFF_FFFF,  32'h0};
    tbl[9]  = '{32'h0000_0004, 4'b0000, 32'h0,          32'h0000_0002};
    tbl[10] = '{32'h0000_000C, 4'b1111, 32'hFFFF_FFFF,  32'h0};
    tbl[11] = '{32'h0000_0008, 4'b0000, 32'h0,          32'h0000_AB34};
    tbl[12] = '{32'h0000_0000, 4'b0010, 32'h0000_00FF,  32'h0};
    tbl[13] = '{32'h0000_0004, 4'b0000, 32'h0,          32'h0000_0002};

    repeat (2) @(posedge clk);
    #1;
    check("reset_tx", 32'(tx_o), 32'd1);
    check("reset_irq", 32'(irq_o), 32'd1);
    check("reset_ready", 32'(ready_o), 32'd0);
    check("reset_rdata", rdata_o, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      bus(tbl[i].addr, tbl[i].we, tbl[i].wdata, rd, lat);
      check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp);
      check($sformatf("tbl%0d_latency", i), 32'(lat), 32'd1);
    end

    bus(32'h8, 4'b0000, 32'h0, rd, lat);
    @(posedge clk); #1;
    check("ready_single_cycle", 32'(ready_o), 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    check("rdata_hold", rdata_o, 32'h0000_AB34);

    set_div(16'd4);
    push(8'hA5, 4, lat);
    @(posedge clk); #1;
    check("start_one_cycle_after_ack", 32'(tx_o), 32'd0);
    check("irq_drop_after_push", 32'(irq_o), 32'd0);
    k = 1;
    while (irq_o !== 1'b1 && k < 200) begin @(posedge clk); #1; k++; end
    check("irq_rise_cycles_after_ack", 32'(k), 32'd42);
    bus(32'h4, 4'b0000, 32'h0, rd, lat);
    check("status_after_single", rd, 32'h0000_0002);

    push(8'h00, 4, lat);
    push(8'hFF, 4, lat);
    wait_idle(400);
    check("b2b_gap_cycles", 32'(last_gap), 32'd0);

    set_div(16'd0);
    push(8'h01, 1, lat);
    push(8'h80, 1, lat);
    wait_idle(200);

    set_div(16'd4);
    push(8'h3C, 4, lat);
    push(8'hC3, 8, lat);
    repeat (12) begin @(posedge clk); #1; end
    set_div(16'd8);
    wait_idle(400);

    set_div(16'd4);
    for (int i = 0; i < DEPTH + 2; i++) begin
      push(8'h10 + 8'(i), 4, lat);
      if (i < DEPTH + 1) check($sformatf("stall_free_lat_%0d", i), 32'(lat), 32'd1);
      else               check("stall_last_write_waited", 32'(lat > 1), 32'd1);
    end
    bus(32'h4, 4'b0000, 32'h0, rd, lat);
    check("status_full_after_stall", rd, 32'h0000_0805);
    wait_idle(1000);

    for (int r = 0; r < 3; r++) begin
      d = $urandom_range(1, 5);
      n = $urandom_range(1, 11);
      set_div(16'(d));
      for (int i = 0; i < n; i++) begin
        push(8'($urandom), d, lat);
        repeat ($urandom_range(0, 3 * d)) begin @(posedge clk); #1; end
      end
      wait_idle(2000);
    end

    set_div(16'd4);
    push(8'h55, 4, lat);
    push(8'hAA, 4, lat);
    repeat (16) begin @(posedge clk); #1; end
    check("tx_low_in_data_bit3", 32'(tx_o), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("tx_high_after_reset_edge", 32'(tx_o), 32'd1);
    rst = 1'b0;
    exp_q.delete();
    fsn = frames_seen;
    bus(32'h4, 4'b0000, 32'h0, rd, lat);
    check("status_empty_after_reset", rd, 32'h0000_0002);
    bus(32'h8, 4'b0000, 32'h0, rd, lat);
    check("div_default_after_reset", rd, 32'd434);
    repeat (120) begin @(posedge clk); #1; end
    check("no_frame_after_reset", 32'(frames_seen), 32'(fsn));
    check("irq_after_reset", 32'(irq_o), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1);
  end

endmodule
